// File: rtl/c2h_cmpt_gen.sv
// C2H completion generator: register-sliced AXI-Stream pass-through with mty
// conversion, per-packet byte counting and a completion-record FIFO.
// Optional feature macro: C2H_CMPT_TIMESTAMP_EN (adds a 32-bit first-beat timestamp).
module c2h_cmpt_gen #(
  parameter int unsigned C_DATA_WIDTH = 512,
  parameter int unsigned QID_W        = 11,
  parameter int unsigned CMPT_DEPTH   = 8,
  localparam int unsigned KW          = C_DATA_WIDTH / 8,
  localparam int unsigned MTY_W       = $clog2(KW),
`ifdef C2H_CMPT_TIMESTAMP_EN
  localparam int unsigned CMPT_W      = 96
`else
  localparam int unsigned CMPT_W      = 64
`endif
) (
  input  logic                    axi_aclk,
  input  logic                    axi_areset,
  input  logic [QID_W-1:0]        qid,
  input  logic [C_DATA_WIDTH-1:0] s_tdata,
  input  logic [KW-1:0]           s_tkeep,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [C_DATA_WIDTH-1:0] m_tdata,
  output logic [MTY_W-1:0]        m_mty,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [CMPT_W-1:0]       cmpt_tdata,
  output logic                    cmpt_tvalid,
  input  logic                    cmpt_tready,
  output logic [31:0]             pkt_count,
  output logic                    err_keep
);

  localparam int unsigned CNT_W = MTY_W + 1;
  localparam int unsigned PTR_W = $clog2(CMPT_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef enum logic {PKT_IDLE, PKT_BODY} pkt_state_t;

  pkt_state_t        state, state_nxt;
  logic              beat_acc, last_acc, first_beat, pop;
  logic [CNT_W-1:0]  beat_bytes, empty_bytes;
  logic              keep_ok, beat_err;
  logic [15:0]       byte_cnt, pkt_len;
  logic [16:0]       len_sum;
  logic [QID_W-1:0]  qid_lat, cur_qid;
  logic              pkt_err, cur_err;
  logic [CMPT_W-1:0] rec;

  logic [CMPT_W-1:0] mem [CMPT_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              fifo_full, fifo_empty;

`ifdef C2H_CMPT_TIMESTAMP_EN
  logic [31:0] ts_cnt, ts_lat, cur_ts;
`endif

  // Handshakes and packet position
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    s_tready   = (!m_tvalid || m_tready) && !(s_tlast && fifo_full);
    beat_acc   = s_tvalid && s_tready;
    last_acc   = beat_acc && s_tlast;
    first_beat = (state == PKT_IDLE);
    pop        = !fifo_empty && cmpt_tready;
  end

  // Byte accounting and keep-format check for the current beat
  always_comb begin
    beat_bytes  = CNT_W'($countones(s_tkeep));
    empty_bytes = CNT_W'(KW) - beat_bytes;
    len_sum     = {1'b0, byte_cnt} + 17'(beat_bytes);
    pkt_len     = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    if (s_tlast)
      keep_ok = (s_tkeep != '0) && ((s_tkeep & (s_tkeep + KW'(1))) == '0);
    else
      keep_ok = (s_tkeep == '1);
    beat_err = !keep_ok;
    cur_qid  = first_beat ? qid : qid_lat;
    cur_err  = (!first_beat && pkt_err) || beat_err;
  end

`ifdef C2H_CMPT_TIMESTAMP_EN
  assign cur_ts = first_beat ? ts_cnt : ts_lat;
`endif

  // Completion record assembled from the live last beat
  always_comb begin
    rec          = '0;
    rec[15:0]    = pkt_len;
    rec[26:16]   = 11'(cur_qid);
    rec[27]      = cur_err;
    rec[63:32]   = pkt_count;
`ifdef C2H_CMPT_TIMESTAMP_EN
    rec[95:64]   = cur_ts;
`endif
  end

  always_comb begin
    state_nxt = state;
    if (beat_acc)
      state_nxt = s_tlast ? PKT_IDLE : PKT_BODY;
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset)
      state <= PKT_IDLE;
    else
      state <= state_nxt;
  end

  // Output register slice
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_mty    <= '0;
      m_tlast  <= 1'b0;
    end else if (beat_acc) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
      m_mty    <= s_tlast ? MTY_W'(empty_bytes) : '0;
      m_tlast  <= s_tlast;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  // Per-packet state and status counters
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      byte_cnt  <= '0;
      qid_lat   <= '0;
      pkt_err   <= 1'b0;
      pkt_count <= '0;
      err_keep  <= 1'b0;
    end else if (beat_acc) begin
      if (first_beat)
        qid_lat <= qid;
      if (beat_err)
        err_keep <= 1'b1;
      if (s_tlast) begin
        byte_cnt  <= '0;
        pkt_err   <= 1'b0;
        pkt_count <= pkt_count + 32'd1;
      end else begin
        byte_cnt <= pkt_len;
        pkt_err  <= cur_err;
      end
    end
  end

`ifdef C2H_CMPT_TIMESTAMP_EN
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      ts_cnt <= '0;
      ts_lat <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (beat_acc && first_beat)
        ts_lat <= ts_cnt;
    end
  end
`endif

  // Completion FIFO; storage is cleared so the idle head reads as zero
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < CMPT_DEPTH; i++)
        mem[PTR_W'(i)] <= '0;
    end else begin
      if (last_acc) begin
        mem[wr_ptr[PTR_W-1:0]] <= rec;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign cmpt_tvalid = !fifo_empty;
  assign cmpt_tdata  = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_c2h_cmpt_gen.sv
// Directed bench for c2h_cmpt_gen: queue-based stream/completion model checked
// every cycle, plus hand-computed literal checks at fixed points.
module tb_c2h_cmpt_gen;

  localparam int unsigned DW    = 512;
  localparam int unsigned KW    = DW / 8;
  localparam int unsigned QW    = 11;
  localparam int unsigned DEPTH = 8;
`ifdef C2H_CMPT_TIMESTAMP_EN
  localparam int unsigned CW = 96;
`else
  localparam int unsigned CW = 64;
`endif
  localparam logic [KW-1:0] ALL1 = '1;

  logic          axi_aclk = 1'b0;
  logic          axi_areset;
  logic [QW-1:0] qid;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast, s_tvalid, s_tready;
  logic [DW-1:0] m_tdata;
  logic [5:0]    m_mty;
  logic          m_tlast, m_tvalid, m_tready;
  logic [CW-1:0] cmpt_tdata;
  logic          cmpt_tvalid, cmpt_tready;
  logic [31:0]   pkt_count;
  logic          err_keep;

  c2h_cmpt_gen #(.C_DATA_WIDTH(DW), .QID_W(QW), .CMPT_DEPTH(DEPTH)) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset), .qid(qid),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_mty(m_mty), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .cmpt_tdata(cmpt_tdata), .cmpt_tvalid(cmpt_tvalid), .cmpt_tready(cmpt_tready),
    .pkt_count(pkt_count), .err_keep(err_keep)
  );

  always #5 axi_aclk = ~axi_aclk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [DW-1:0] d;
    logic [5:0]    mty;
    logic          last;
  } beat_t;

  beat_t       exp_beats[$];
  logic [63:0] exp_cmpt[$];
  bit          mdl_in_pkt;
  logic [10:0] mdl_qid;
  int          mdl_len;
  bit          mdl_err;
  logic [31:0] mdl_seq;
  bit          mdl_err_keep;

  always @(negedge axi_aclk) begin : monitor
    int    pc;
    bit    bad, exp_rdy;
    beat_t b;
    if (axi_areset) begin
      exp_beats.delete();
      exp_cmpt.delete();
      mdl_in_pkt   = 0;
      mdl_len      = 0;
      mdl_err      = 0;
      mdl_seq      = '0;
      mdl_err_keep = 0;
    end else begin
      chk("m_tvalid", m_tvalid, exp_beats.size() != 0);
      if (m_tvalid === 1'b1 && exp_beats.size() != 0) begin
        chk("m_tdata", m_tdata, exp_beats[0].d);
        chk("m_mty", m_mty, exp_beats[0].mty);
        chk("m_tlast", m_tlast, exp_beats[0].last);
      end
      chk("cmpt_tvalid", cmpt_tvalid, exp_cmpt.size() != 0);
      if (cmpt_tvalid === 1'b1 && exp_cmpt.size() != 0)
        chk("cmpt_tdata", cmpt_tdata[63:0], exp_cmpt[0]);
      chk("pkt_count", pkt_count, mdl_seq);
      chk("err_keep", err_keep, mdl_err_keep);
      exp_rdy = (exp_beats.size() == 0 || m_tready) &&
                !(s_tlast && exp_cmpt.size() == DEPTH);
      chk("s_tready", s_tready, exp_rdy);

      if (m_tvalid && m_tready && exp_beats.size() != 0) void'(exp_beats.pop_front());
      if (cmpt_tvalid && cmpt_tready && exp_cmpt.size() != 0) void'(exp_cmpt.pop_front());
      if (s_tvalid && s_tready) begin
        pc = 0;
        for (int i = 0; i < KW; i++) pc += int'(s_tkeep[i]);
        b.d    = s_tdata;
        b.last = s_tlast;
        b.mty  = s_tlast ? 6'((KW - pc) % KW) : 6'd0;
        exp_beats.push_back(b);
        if (!mdl_in_pkt) begin
          mdl_qid = 11'(qid);
          mdl_len = 0;
          mdl_err = 0;
        end
        mdl_len = (mdl_len + pc > 65535) ? 65535 : mdl_len + pc;
        if (s_tlast)
          bad = (pc == 0) || ({1'b0, s_tkeep} != ((65'd1 << pc) - 65'd1));
        else
          bad = (s_tkeep != ALL1);
        mdl_err      = mdl_err | bad;
        mdl_err_keep = mdl_err_keep | bad;
        if (s_tlast) begin
          exp_cmpt.push_back({mdl_seq, 4'b0000, mdl_err, mdl_qid, 16'(mdl_len)});
          mdl_seq    = mdl_seq + 32'd1;
          mdl_in_pkt = 0;
        end else begin
          mdl_in_pkt = 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [DW-1:0] mk_data(input int p, input int b);
    logic [31:0] w;
    w = 32'(p * 256 + b) ^ 32'h5A00_C300;
    return {16{w}};
  endfunction

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input logic [QW-1:0] q);
    int  n = 0;
    bit  will;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l; qid = q;
    forever begin
      @(negedge axi_aclk);
      will = s_tready;
      tick();
      if (will) break;
      if (++n > 300) begin
        n_cmp++; n_fail++;
        $display("FAIL beat_timeout: got no accept after %0d cycles, required accept", n);
        break;
      end
    end
    s_tvalid = 1'b0;
  endtask

  // Later beats drive a different qid to show the first-beat value is kept
  task automatic send_pkt(input int pid, input logic [QW-1:0] q, input int nb,
                          input logic [KW-1:0] last_k, input logic [KW-1:0] mid_k);
    for (int b = 0; b < nb; b++)
      send_beat(mk_data(pid, b), (b == nb - 1) ? last_k : mid_k, b == nb - 1,
                (b == 0) ? q : ~q);
  endtask

  task automatic drain();
    int n = 0;
    cmpt_tready = 1'b1;
    while (cmpt_tvalid !== 1'b0) begin
      tick();
      if (++n > 50) begin
        n_cmp++; n_fail++;
        $display("FAIL drain_timeout: got cmpt_tvalid=1 after %0d cycles, required 0", n);
        break;
      end
    end
    cmpt_tready = 1'b0;
  endtask

  bit drv_done;

  task automatic wait_done();
    int n = 0;
    while (!drv_done) begin
      tick();
      if (++n > 400) begin
        n_cmp++; n_fail++;
        $display("FAIL driver_timeout: got unfinished driver, required completion");
        break;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    axi_areset = 1'b1; qid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    s_tvalid = 1'b0; m_tready = 1'b1; cmpt_tready = 1'b0;
    repeat (3) tick();
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_cmpt_tvalid", cmpt_tvalid, 1'b0);
    chk("rst_pkt_count", pkt_count, 32'd0);
    chk("rst_err_keep", err_keep, 1'b0);
    axi_areset = 1'b0;
    repeat (2) tick();

    // single-beat packet, 16 bytes
    send_pkt(1, 11'd5, 1, 64'h0000_0000_0000_FFFF, ALL1);
    chk("t1_m_tvalid", m_tvalid, 1'b1);
    chk("t1_m_mty", m_mty, 6'd48);
    chk("t1_m_tlast", m_tlast, 1'b1);
    chk("t1_record", cmpt_tdata[63:0], 64'h0000_0000_0005_0010);
    chk("t1_pkt_count", pkt_count, 32'd1);
    drain();

    // three beats, 64+64+8 bytes
    send_pkt(2, 11'd7, 3, 64'h0000_0000_0000_00FF, ALL1);
    chk("t2_m_mty", m_mty, 6'd56);
    chk("t2_record", cmpt_tdata[63:0], 64'h0000_0001_0007_0088);
    drain();

    // output back-pressure: slice fills and input stalls
    m_tready = 1'b0;
    drv_done = 0;
    fork
      begin
        send_pkt(3, 11'd3, 4, 64'h0000_0000_FFFF_FFFF, ALL1);
        drv_done = 1;
      end
    join_none
    repeat (5) tick();
    chk("t3_s_tready", s_tready, 1'b0);
    chk("t3_m_tvalid", m_tvalid, 1'b1);
    chk("t3_m_tlast", m_tlast, 1'b0);
    m_tready = 1'b1;
    wait_done();
    tick();
    chk("t3_record", cmpt_tdata[63:0], 64'h0000_0002_0003_00E0);
    chk("t3_pkt_count", pkt_count, 32'd3);
    drain();

    // completion FIFO full: ninth last beat stalls until one pop
    drv_done = 0;
    fork
      begin
        for (int i = 0; i < DEPTH + 1; i++)
          send_pkt(10 + i, 11'(i), 1, 64'h0000_0000_0000_00FF, ALL1);
        drv_done = 1;
      end
    join_none
    repeat (30) tick();
    chk("t4_s_tready_full", s_tready, 1'b0);
    chk("t4_pkt_count_full", pkt_count, 32'd11);
    chk("t4_cmpt_head", cmpt_tdata[63:0], 64'h0000_0003_0000_0008);
    cmpt_tready = 1'b1;
    tick();
    cmpt_tready = 1'b0;
    wait_done();
    chk("t4_pkt_count_after", pkt_count, 32'd12);
    drain();

    // keep errors: non-contiguous last keep, then a clean packet, then bad middle keep
    send_pkt(30, 11'd9, 2, 64'h0000_0000_0000_0005, ALL1);
    chk("t5_m_mty", m_mty, 6'd62);
    chk("t5_err_keep", err_keep, 1'b1);
    chk("t5_record", cmpt_tdata[63:0], 64'h0000_000C_0809_0042);
    drain();
    send_pkt(31, 11'd2, 1, ALL1, ALL1);
    chk("t5_clean_record", cmpt_tdata[63:0], 64'h0000_000D_0002_0040);
    chk("t5_err_sticky", err_keep, 1'b1);
    drain();
    send_pkt(32, 11'd6, 2, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE);
    drain();

    // reset after beat 2 of 3
    send_beat(mk_data(40, 0), ALL1, 1'b0, 11'd1);
    send_beat(mk_data(40, 1), ALL1, 1'b0, 11'd1);
    axi_areset = 1'b1;
    #1;
    chk("t6_m_tvalid", m_tvalid, 1'b0);
    chk("t6_m_tdata", m_tdata, '0);
    chk("t6_m_mty", m_mty, 6'd0);
    chk("t6_m_tlast", m_tlast, 1'b0);
    chk("t6_cmpt_tvalid", cmpt_tvalid, 1'b0);
    chk("t6_pkt_count", pkt_count, 32'd0);
    chk("t6_err_keep", err_keep, 1'b0);
    repeat (2) tick();
    axi_areset = 1'b0;
    tick();
    send_pkt(41, 11'd4, 2, 64'h0000_0000_0000_FFFF, ALL1);
    chk("t6_record", cmpt_tdata[63:0], 64'h0000_0000_0004_0050);
    drain();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
